phy_bmc_encoder: RTL
====================

# phy_bmc_encoder

Biphase Mark Code transmitter for the USB-PD PHY, the transmit-side counterpart of the BMC decoder. Accepts a serial bit stream from the PHY framing logic over a valid/ready handshake, produces the BMC line waveform at a half-bit period selected by `TIME_SCALE_FLAG`, and closes each transmission with a fixed low hold before releasing the line. Its line timing matches the decoder's sampling point, so the two can be looped back directly.

## Interface
- `TIME_SCALE_FLAG`, 0: half-bit length HALF in clk cycles. 0→4, 1→8, 2→16, 3→1. Bit period is 2*HALF.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `phy_bmc_encoder_clr`  in  1  synchronous abort. Priority is below `rst` and above everything else.
- `phy_bmc_encoder_in_valid`  in  1  source has a bit to send.
- `phy_bmc_encoder_in`  in  1  data bit.
- `phy_bmc_encoder_in_last`  in  1  marks the final bit of a frame. Qualified by valid.
- `phy_bmc_encoder_in_ready`  out  1  encoder accepts a bit this cycle.
- `phy_bmc_encoder_out`  out  1  BMC line level. Idle/released level is 1.
- `phy_bmc_encoder_out_en`  out  1  line driver enable.
- `phy_bmc_encoder_busy`  out  1  state is not IDLE.
- `phy_bmc_encoder_done`  out  1  one-cycle pulse when the line is released after TAIL.
- `phy_bmc_encoder_underrun`  out  1  one-cycle pulse when a bit boundary arrives with no valid bit and no prior last.

## Operation
- State machine has three states: IDLE, ACTIVE, TAIL.
- Internal registers:
  - line level `lvl`
  - half-bit counter `cnt` (0..HALF-1, 5 bits)
  - half flag `h` (0 = first half, 1 = second half)
  - current bit `b`
  - last flag `lf`
- `rst` or `clr` forces: state=IDLE, `lvl`=1, `out_en`=0, `cnt`=0, `h`=0, `lf`=0, all pulses 0. A `clr` issued mid-frame aborts immediately and does not pulse `done`.
- IDLE:
  - `in_ready`=1.
  - On valid&&ready: capture `b`←in and `lf`←in_last; toggle `lvl`; set `out_en`=1, `cnt`=0, `h`=0; go to ACTIVE.
- ACTIVE: `cnt` increments each cycle. When `cnt`==HALF-1 it wraps to 0 and `h` flips.
  - End of first half (`cnt`==HALF-1, `h`=0): if `b`=1, toggle `lvl`; if `b`=0, no change.
  - `in_ready`=1 only when `cnt`==HALF-1, `h`=1 and `lf`=0. Combinational from registered state.
  - At the end of the second half:
    - If `lf`=1: toggle `lvl` to 0 if `lvl`=1, otherwise keep 0. Go to TAIL.
    - Else if valid: capture the new `b`/`lf` and toggle `lvl` (bit boundary).
    - Else: pulse `underrun`, force `lvl`=0, go to TAIL.
- TAIL: `lvl`=0 and `out_en`=1 for 2*HALF cycles. Then `lvl`=1, `out_en`=0, pulse `done`, go to IDLE.
- Every bit has a transition at its start; a 1 bit also has a transition at mid-bit.
- `in_ready` is 0 in TAIL.

## Timing
- `out`=`lvl` and `out_en` are registered.
- Reset values: `out`=1, `out_en`=0, `busy`=0, `done`=0, `underrun`=0. `in_ready`=1 after reset (IDLE).
- If the first bit is accepted on cycle T, `out` drops to 0 and `out_en` rises at T+1.
- Each bit occupies exactly 2*HALF cycles; bit k starts at T+1+k*2*HALF.
- A following bit must be presented while `in_ready` is high, i.e. the final cycle of the current bit. Back-to-back bits therefore have zero gap.
- TAIL begins at T+1+N*2*HALF for an N-bit frame. `done` pulses and `out_en` falls at T+1+(N+1)*2*HALF.
- `busy` is registered from state and rises at T+1.
- valid asserted without ready has no effect; the source holds its data.
- `clr` together with valid: `clr` wins and the bit is not accepted.
- HALF=1 (flag 3): the mid-bit and boundary decisions fall on alternating cycles. `cnt` stays 0.

## Test plan
- Flag 0, reset released, no stimulus → `out`=1, `out_en`=0, `in_ready`=1, `busy`=0 indefinitely.
- Flag 0, send bits 1,0 (0 marked last), accepted at T → from T+1 `out` = 0000 1111 0000 0000 (bits), then 00000000 (TAIL), then at T+25 `out`=1, `out_en`=0, `done` pulses once.
- Flag 0, frame 0,1,1,0,1 (last on the final bit), valid held continuously → no underrun. Looped into the decoder with matching flag, the decoder outputs 0,1,1,0,1 on out_en pulses.
- Flag 0, drop valid after the second bit (no last) → `underrun` pulses at T+16, `out`=0 for 8 cycles, then `done` and release.
- Flag 0, assert `clr` mid-frame at cycle T+6 → at T+7 `out`=1, `out_en`=0, `busy`=0, and no `done` pulse.
- Flags 1, 2 and 3, single 1 bit marked last → `out` low for HALF=8/16/1 cycles, high for HALF, then low for 2*HALF in TAIL, then released.

Source files
------------

// File: rtl/phy_bmc_encoder_if.sv
// ----------------------------------------------------------------------------
// phy_bmc_encoder_if
// Serial bit handshake between the PHY framing logic (master) and the BMC
// encoder (slave).
//   phy_bmc_encoder_in_valid : master -> slave, a bit is presented
//   phy_bmc_encoder_in       : master -> slave, data bit
//   phy_bmc_encoder_in_last  : master -> slave, final bit of the frame
//   phy_bmc_encoder_in_ready : slave -> master, bit is taken this cycle
// ----------------------------------------------------------------------------
interface phy_bmc_encoder_if;

    logic phy_bmc_encoder_in_valid;
    logic phy_bmc_encoder_in;
    logic phy_bmc_encoder_in_last;
    logic phy_bmc_encoder_in_ready;

    // Bit source side
    modport master (
        output phy_bmc_encoder_in_valid,
        output phy_bmc_encoder_in,
        output phy_bmc_encoder_in_last,
        input  phy_bmc_encoder_in_ready
    );

    // Encoder side
    modport slave (
        input  phy_bmc_encoder_in_valid,
        input  phy_bmc_encoder_in,
        input  phy_bmc_encoder_in_last,
        output phy_bmc_encoder_in_ready
    );

endinterface

// File: rtl/phy_bmc_encoder.sv
// ----------------------------------------------------------------------------
// phy_bmc_encoder
// Biphase Mark Code transmitter for the USB-PD PHY. Takes one bit at a time
// over a valid/ready handshake, drives the BMC line with a half-bit length
// chosen by TIME_SCALE_FLAG, and ends each frame with a low hold of one bit
// period before releasing the line high.
//
// Parameters
//   TIME_SCALE_FLAG : half-bit length HALF, 0->4, 1->8, 2->16, 3->1 clocks
// Ports
//   clk                       : system clock, rising edge
//   rst                       : synchronous active-high reset
//   phy_bmc_encoder_clr       : synchronous abort, below rst, above all else
//   bus (slave)               : valid / data / last / ready bit handshake
//   phy_bmc_encoder_out       : BMC line level, released level is 1
//   phy_bmc_encoder_out_en    : line driver enable
//   phy_bmc_encoder_busy      : encoder is not idle
//   phy_bmc_encoder_done      : one-cycle pulse when the line is released
//   phy_bmc_encoder_underrun  : pulse on a bit boundary with no bit available
// ----------------------------------------------------------------------------
module phy_bmc_encoder #(
    parameter int unsigned TIME_SCALE_FLAG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              phy_bmc_encoder_clr,
    phy_bmc_encoder_if.slave  bus,
    output logic              phy_bmc_encoder_out,
    output logic              phy_bmc_encoder_out_en,
    output logic              phy_bmc_encoder_busy,
    output logic              phy_bmc_encoder_done,
    output logic              phy_bmc_encoder_underrun
);

    // Half-bit length in clock cycles
    localparam int unsigned HALF = (TIME_SCALE_FLAG == 0) ? 4  :
                                   (TIME_SCALE_FLAG == 1) ? 8  :
                                   (TIME_SCALE_FLAG == 2) ? 16 : 1;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_TAIL   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             lvl_q,   lvl_d;
    logic             en_q,    en_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             h_q,     h_d;
    logic             b_q,     b_d;
    logic             lf_q,    lf_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             ready_c;
    logic             underrun_c;
    logic             half_end_c;

    // Last cycle of the current half-bit
    assign half_end_c = (cnt_q == HALF_M1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lvl_q   <= 1'b1;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            h_q     <= 1'b0;
            b_q     <= 1'b0;
            lf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            b_q     <= b_d;
            lf_q    <= lf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and handshake logic
    always_comb begin
        state_d    = state_q;
        lvl_d      = lvl_q;
        en_d       = en_q;
        cnt_d      = cnt_q;
        h_d        = h_q;
        b_d        = b_q;
        lf_d       = lf_q;
        done_d     = 1'b0;
        ready_c    = 1'b0;
        underrun_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
            end
            ST_ACTIVE: begin
                // Next bit may only be offered on the final cycle of a non-last bit
                ready_c = half_end_c && h_q && !lf_q;
            end
            default: begin
                ready_c = 1'b0;
            end
        endcase

        if (phy_bmc_encoder_clr) begin
            // Abort: drop the frame immediately, no done pulse
            state_d = ST_IDLE;
            lvl_d   = 1'b1;
            en_d    = 1'b0;
            cnt_d   = '0;
            h_d     = 1'b0;
            lf_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.phy_bmc_encoder_in_valid) begin
                        b_d     = bus.phy_bmc_encoder_in;
                        lf_d    = bus.phy_bmc_encoder_in_last;
                        lvl_d   = ~lvl_q;
                        en_d    = 1'b1;
                        cnt_d   = '0;
                        h_d     = 1'b0;
                        state_d = ST_ACTIVE;
                    end
                end

                ST_ACTIVE: begin
                    cnt_d = half_end_c ? '0 : cnt_q + CNT_W'(1);
                    if (half_end_c) begin
                        h_d = ~h_q;
                    end

                    if (half_end_c && !h_q) begin
                        // Mid-bit transition only for a 1
                        if (b_q) begin
                            lvl_d = ~lvl_q;
                        end
                    end else if (half_end_c && h_q) begin
                        if (lf_q) begin
                            lvl_d   = 1'b0;
                            state_d = ST_TAIL;
                        end else if (bus.phy_bmc_encoder_in_valid) begin
                            // Bit boundary: every bit starts with a transition
                            b_d   = bus.phy_bmc_encoder_in;
                            lf_d  = bus.phy_bmc_encoder_in_last;
                            lvl_d = ~lvl_q;
                        end else begin
                            underrun_c = 1'b1;
                            lvl_d      = 1'b0;
                            state_d    = ST_TAIL;
                        end
                    end
                end

                ST_TAIL: begin
                    // Hold low for one full bit period, reusing cnt/h as timer
                    lvl_d = 1'b0;
                    cnt_d = half_end_c ? '0 : cnt_q + CNT_W'(1);
                    if (half_end_c) begin
                        h_d = ~h_q;
                    end
                    if (half_end_c && h_q) begin
                        lvl_d   = 1'b1;
                        en_d    = 1'b0;
                        lf_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    lvl_d   = 1'b1;
                    en_d    = 1'b0;
                    cnt_d   = '0;
                    h_d     = 1'b0;
                    lf_d    = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.phy_bmc_encoder_in_ready = ready_c;
    assign phy_bmc_encoder_out          = lvl_q;
    assign phy_bmc_encoder_out_en       = en_q;
    assign phy_bmc_encoder_busy         = busy_q;
    assign phy_bmc_encoder_done         = done_q;
    assign phy_bmc_encoder_underrun     = underrun_c & ~rst;

endmodule
